// File: rtl/safe_lock_sequencer.sv
// safe_lock_sequencer: top-level control FSM of the safe lock.
// Collects keypad digits into a code, checks it against SECRET, opens a timed
// window on success and enforces a timed lockout after repeated failures.
// It drives one external interval timer through the timer_start/timer_done pair.
// Optional build macro LOCK_FAIL_CNT_EN adds a saturating fail_count output.
module safe_lock_sequencer #(
    parameter int                                CODE_DIGITS       = 4,
    parameter int                                DIGIT_W           = 4,
    parameter logic [CODE_DIGITS*DIGIT_W-1:0]    SECRET            = 16'h1234,
    parameter int                                MAX_ATTEMPTS      = 3,
    parameter int                                LOCKOUT_INTERVALS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               clear,
    input  logic               relock,
    input  logic               timer_done,
    output logic               timer_start,
    output logic               locked,
    output logic               unlocked,
    output logic               lockout,
    output logic               error,
    output logic [1:0]         attempts_left
`ifdef LOCK_FAIL_CNT_EN
    ,
    output logic [7:0]         fail_count
`endif
);

    localparam int CODE_W = CODE_DIGITS * DIGIT_W;
    localparam int CNT_W  = $clog2(CODE_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(CODE_DIGITS);
    localparam logic [1:0]       ATT_MAX    = 2'(MAX_ATTEMPTS);
    localparam logic [3:0]       DWELL_INIT = 4'(LOCKOUT_INTERVALS);

    typedef enum logic [2:0] {
        S_LOCKED  = 3'd0,
        S_ENTRY   = 3'd1,
        S_VERIFY  = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t              state;
    logic [CODE_W-1:0]   code_q;
    logic [CNT_W-1:0]    digit_cnt;
    logic [3:0]          dwell_cnt;

    logic [CODE_W-1:0]   code_shift;
    logic [CNT_W-1:0]    digit_cnt_inc;
    logic                timer_expired;

    // New digit enters at the LS end so the first digit ends up in the MS slot.
    assign code_shift    = {code_q[CODE_W-DIGIT_W-1:0], digit};
    assign digit_cnt_inc = digit_cnt + CNT_W'(1);
    // While timer_start is high the timer still shows its stale zero, so its done flag is meaningless.
    assign timer_expired = timer_done & ~timer_start;

    // Status flags {locked, unlocked, lockout} that belong to a given state.
    function automatic logic [2:0] state_flags(input state_t s);
        case (s)
            S_OPEN:    state_flags = 3'b010;
            S_LOCKOUT: state_flags = 3'b001;
            default:   state_flags = 3'b100;
        endcase
    endfunction

    // Single sequencer: state, code capture, attempt/dwell bookkeeping and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_LOCKED;
            code_q        <= '0;
            digit_cnt     <= '0;
            dwell_cnt     <= '0;
            timer_start   <= 1'b0;
            error         <= 1'b0;
            locked        <= 1'b1;
            unlocked      <= 1'b0;
            lockout       <= 1'b0;
            attempts_left <= ATT_MAX;
`ifdef LOCK_FAIL_CNT_EN
            fail_count    <= 8'd0;
`endif
        end else begin
            timer_start <= 1'b0;
            error       <= 1'b0;
            case (state)
                S_LOCKED: begin
                    if (digit_valid) begin
                        code_q      <= code_shift;
                        digit_cnt   <= CNT_W'(1);
                        timer_start <= 1'b1;
                        state       <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (clear) begin
                        code_q    <= '0;
                        digit_cnt <= '0;
                        state     <= S_LOCKED;
                    end else if (digit_valid) begin
                        code_q      <= code_shift;
                        digit_cnt   <= digit_cnt_inc;
                        timer_start <= 1'b1;
                        if (digit_cnt_inc == CNT_FULL) begin
                            state <= S_VERIFY;
                        end
                    end else if (timer_expired) begin
                        code_q    <= '0;
                        digit_cnt <= '0;
                        state     <= S_LOCKED;
                    end
                end
                S_VERIFY: begin
                    code_q    <= '0;
                    digit_cnt <= '0;
                    if (code_q == SECRET) begin
                        attempts_left                 <= ATT_MAX;
                        timer_start                   <= 1'b1;
                        state                         <= S_OPEN;
                        {locked, unlocked, lockout}   <= state_flags(S_OPEN);
                    end else begin
                        error <= 1'b1;
`ifdef LOCK_FAIL_CNT_EN
                        if (fail_count != 8'hFF) begin
                            fail_count <= fail_count + 8'd1;
                        end
`endif
                        if (attempts_left <= 2'd1) begin
                            attempts_left               <= 2'd0;
                            dwell_cnt                   <= DWELL_INIT;
                            timer_start                 <= 1'b1;
                            state                       <= S_LOCKOUT;
                            {locked, unlocked, lockout} <= state_flags(S_LOCKOUT);
                        end else begin
                            attempts_left <= attempts_left - 2'd1;
                            state         <= S_LOCKED;
                        end
                    end
                end
                S_OPEN: begin
                    if (relock || timer_expired) begin
                        state                       <= S_LOCKED;
                        {locked, unlocked, lockout} <= state_flags(S_LOCKED);
                    end
                end
                S_LOCKOUT: begin
                    if (timer_expired) begin
                        if (dwell_cnt <= 4'd1) begin
                            dwell_cnt                   <= 4'd0;
                            attempts_left               <= ATT_MAX;
                            state                       <= S_LOCKED;
                            {locked, unlocked, lockout} <= state_flags(S_LOCKED);
                        end else begin
                            dwell_cnt   <= dwell_cnt - 4'd1;
                            timer_start <= 1'b1;
                        end
                    end
                end
                default: begin
                    code_q                      <= '0;
                    digit_cnt                   <= '0;
                    state                       <= S_LOCKED;
                    {locked, unlocked, lockout} <= state_flags(S_LOCKED);
                end
            endcase
        end
    end

endmodule

// File: doc/safe_lock_sequencer.md
Name: safe_lock_sequencer

Overview:
- Top-level control FSM of the safe lock.
- Collects keypad digits into a code, compares it against the stored secret, and grants a timed unlock window.
- Enforces lockout after repeated failures.
- Sequences one external interval timer instance (start/done handshake) for the inter-digit timeout, the open window and the lockout dwell.

Parameters:
- CODE_DIGITS, 4, digits per code entry (2..8)
- DIGIT_W, 4, bits per digit
- SECRET, 16'h1234, stored code; CODE_DIGITS*DIGIT_W bits; first entered digit occupies the MS digit
- MAX_ATTEMPTS, 3, wrong codes tolerated before lockout (1..3)
- LOCKOUT_INTERVALS, 3, timer expirations spent in lockout (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- digit_valid  in  1  one-cycle strobe, digit present
- digit  in  DIGIT_W  keypad digit value
- clear  in  1  abandon partial entry
- relock  in  1  close the safe early
- timer_done  in  1  interval timer expired (level; high while timer idle at zero)
- timer_start  out  1  one-cycle pulse, reloads interval timer
- locked  out  1  safe closed (states LOCKED/ENTRY/VERIFY)
- unlocked  out  1  safe open (state OPEN)
- lockout  out  1  lockout active (state LOCKOUT)
- error  out  1  one-cycle pulse on a wrong code
- attempts_left  out  2  remaining tries before lockout

Behaviour:
- All outputs are registered.
- Reset values: state LOCKED, locked=1, unlocked=0, lockout=0, error=0, timer_start=0, attempts_left=MAX_ATTEMPTS, digit count=0, code shift register=0.
- rst dominates everything, including mid-entry, OPEN and LOCKOUT.
- Digit capture: code register shifts left by DIGIT_W, new digit enters the LS position. Digit count increments.
- Timer qualification:
  - timer_done is ignored in any cycle where timer_start=1, because the timer is still showing the stale zero.
  - Otherwise timer_done is honoured only in ENTRY, OPEN and LOCKOUT.
- LOCKED:
  - digit_valid -> capture the digit (count=1), pulse timer_start, go to ENTRY.
  - clear, relock and timer_done are ignored.
- ENTRY:
  - clear -> discard the entry (count=0), go to LOCKED. clear beats digit_valid in the same cycle.
  - digit_valid -> capture, pulse timer_start. If count reaches CODE_DIGITS, go to VERIFY.
  - Qualified timer_done with no digit_valid -> inter-digit timeout: discard, go to LOCKED. No attempt is charged.
  - digit_valid beats timer_done in the same cycle.
- VERIFY (exactly 1 cycle; digit_valid ignored):
  - Code == SECRET -> go to OPEN, pulse timer_start, set attempts_left=MAX_ATTEMPTS.
  - Mismatch -> pulse error and decrement attempts_left.
    - If the new value is 0 -> go to LOCKOUT, pulse timer_start, load the dwell counter with LOCKOUT_INTERVALS.
    - Else -> go to LOCKED.
  - count is cleared on exit.
- OPEN:
  - unlocked=1. digit_valid and clear are ignored.
  - relock or qualified timer_done -> go to LOCKED. Both in the same cycle give the same result.
- LOCKOUT:
  - lockout=1. digit_valid, clear and relock are ignored.
  - Each qualified timer_done decrements the dwell counter.
    - If the counter is nonzero after decrement -> pulse timer_start again.
    - If zero -> go to LOCKED and restore attempts_left=MAX_ATTEMPTS.
- Timing with the 10-cycle-reload timer:
  - timer_start in cycle k makes timer_done visible in cycle k+11.
  - The FSM reacts at the end of that cycle, so one interval = 12 cycles of residency.
- Arithmetic rules:
  - attempts_left never underflows.
  - The dwell counter is 4 bits.
  - Comparison is a full-width equality on CODE_DIGITS*DIGIT_W bits. Unused parameter combinations are illegal.

Optional Feature:
- Macro: LOCK_FAIL_CNT_EN.
- When defined:
  - Adds output fail_count [7:0], reset to 0.
  - Increments on every error pulse and saturates at 255. Cleared only by rst.
  - Is not cleared by a successful unlock or by the end of lockout.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then enter 1,2,3,4 on consecutive cycles:
  - VERIFY is the cycle after the 4th digit.
  - unlocked=1 for exactly 12 cycles, then locked=1.
  - attempts_left=3 throughout.
- Enter 1,2,3,5 three times:
  - error pulses 3 times; attempts_left goes 2, 1, then 0 with lockout=1.
  - lockout lasts 36 cycles; digits entered during lockout are ignored.
  - Afterwards locked=1 and attempts_left=3.
- Enter 1,2 then idle:
  - ENTRY times out 11 cycles after the last timer_start.
  - Returns to LOCKED; attempts_left unchanged; no error pulse.
- Enter 1,2, assert clear together with digit_valid=3:
  - The entry is discarded.
  - Then 1,2,3,4 unlocks.
- Unlock, then assert relock 3 cycles into OPEN:
  - locked=1 the next cycle.
  - A relock pulse while in LOCKED has no effect.
- Assert rst mid-LOCKOUT and mid-ENTRY: all outputs return to reset values immediately. With LOCK_FAIL_CNT_EN:
  - 300 wrong codes leave fail_count=255.
  - rst clears it.
